// File: rtl/stereo_i2s_tx_pkg.sv
// Shared audio definitions for the stereo I2S transmitter.
package stereo_i2s_tx_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int UNDERRUN_CNT_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // Word select is high from the last left slot up to the second-to-last
  // right slot, so it leads the data by one bit clock.
  function automatic logic lr_for_slot(input int slot, input int width);
    return (slot >= width - 1) && (slot <= 2 * width - 2);
  endfunction

endpackage

// File: rtl/stereo_i2s_tx_clk_gen.sv
// Bit-clock divider and slot sequencer for the I2S transmitter.
module i2s_clk_gen
  import stereo_i2s_tx_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter  int BCLK_DIV     = 4,
  localparam int SLOT_W       = $clog2(2 * SAMPLE_WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              bclk,
  output logic              frame_start,
  output logic              slot_tick,   // a slot begins at the coming edge
  output logic              frame_tick,  // that slot is slot 0
  output logic              boundary,    // slot 0 that follows a finished frame
  output logic [SLOT_W-1:0] slot_nxt
);

  localparam int SLOTS = 2 * SAMPLE_WIDTH;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              bclk_q, bclk_d;
  logic              started_q, started_d;
  logic              frame_start_q, frame_start_d;
  logic              div_wrap;
  logic              last_slot;

  assign div_wrap  = (div_q == DIV_W'(BCLK_DIV - 1));
  assign last_slot = (slot_q == SLOT_W'(SLOTS - 1));

  // Divider and slot sequencing; the very first slot starts one clk after run rises.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    div_d         = div_q;
    bclk_d        = bclk_q;
    slot_d        = slot_q;
    started_d     = started_q;
    slot_tick     = 1'b0;
    slot_nxt      = slot_q;
    if (run) begin
      if (!started_q) begin
        started_d = 1'b1;
        slot_tick = 1'b1;
        slot_nxt  = '0;
        div_d     = '0;
        bclk_d    = 1'b0;
      end else begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          bclk_d = !bclk_q;
          // A falling bclk edge opens the next slot.
          if (bclk_q) begin
            slot_tick = 1'b1;
            slot_nxt  = last_slot ? '0 : slot_q + 1'b1;
          end
        end
      end
    end
    if (slot_tick) slot_d = slot_nxt;
    frame_tick    = slot_tick && (slot_nxt == '0);
    boundary      = frame_tick && started_q;
    frame_start_d = frame_tick;
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      div_q         <= '0;
      slot_q        <= '0;
      bclk_q        <= 1'b0;
      started_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      slot_q        <= slot_d;
      bclk_q        <= bclk_d;
      started_q     <= started_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bclk        = bclk_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/stereo_i2s_tx.sv
// Stereo I2S transmitter: one-deep sample buffer, framing FSM and serialiser.
module stereo_i2s_tx
  import stereo_i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int BCLK_DIV     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   sample_left,
  input  logic [SAMPLE_WIDTH-1:0]   sample_right,
  output logic                      sample_ready,
  output logic                      bclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      frame_start,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam int FW     = 2 * SAMPLE_WIDTH;
  localparam int SLOT_W = $clog2(FW);

  tx_state_e                 state_q, state_d;
  logic [FW-1:0]             buf_q, buf_d;
  logic                      buf_full_q, buf_full_d;
  logic [FW-1:0]             frame_q, frame_d;
  logic [FW-1:0]             shift_q, shift_d;
  logic                      lrclk_q, lrclk_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  logic              run;
  logic              slot_tick;
  logic              frame_tick;
  logic              boundary;
  logic [SLOT_W-1:0] slot_nxt;
  logic              unload;
  logic              transfer;

  assign run = (state_q == ST_RUN);

  i2s_clk_gen #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BCLK_DIV     (BCLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bclk        (bclk),
    .frame_start (frame_start),
    .slot_tick   (slot_tick),
    .frame_tick  (frame_tick),
    .boundary    (boundary),
    .slot_nxt    (slot_nxt)
  );

  // The buffer frees up in the cycle a frame boundary drains it, so a
  // refill can land in that same cycle; ready is forced low during reset.
  assign unload       = boundary && buf_full_q;
  assign sample_ready = reset && (!buf_full_q || unload);
  assign transfer     = sample_valid && sample_ready;

  // Next-state logic: handshake, frame reload/underrun and serialiser.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    lrclk_d    = lrclk_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // The first pair bypasses the buffer and feeds the first frame.
        if (transfer) begin
          state_d = ST_RUN;
          frame_d = {sample_left, sample_right};
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (buf_full_q) begin
            frame_d    = buf_q;
            buf_full_d = 1'b0;
          end else begin
            // Nothing new: repeat the previous pair and record the underrun.
            underrun_d = 1'b1;
            if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
          end
        end
        if (transfer) begin
          buf_d      = {sample_left, sample_right};
          buf_full_d = 1'b1;
        end
        if (frame_tick)     shift_d = frame_d;
        else if (slot_tick) shift_d = {shift_q[FW-2:0], 1'b0};
        if (slot_tick)      lrclk_d = lr_for_slot(int'(slot_nxt), SAMPLE_WIDTH);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the sample buffer and frame word are cleared on reset too, so an
    // aborted stream leaves no stale pair behind.
    if (!reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      frame_q    <= '0;
      shift_q    <= '0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign sdata          = shift_q[FW-1];
  assign lrclk          = lrclk_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_stereo_i2s_tx.sv
// Self-checking bench for stereo_i2s_tx (W=16, BCLK_DIV=2).
module tb_stereo_i2s_tx;

  localparam int W   = 16;
  localparam int DIV = 2;
  localparam int FW  = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  sample_left = '0;
  logic [W-1:0]  sample_right = '0;
  logic          sample_ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          frame_start;
  logic          underrun;
  logic [7:0]    underrun_count;

  stereo_i2s_tx #(
    .SAMPLE_WIDTH (W),
    .BCLK_DIV     (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_ready   (sample_ready),
    .bclk           (bclk),
    .lrclk          (lrclk),
    .sdata          (sdata),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [FW-1:0] word;
    logic          ur;
  } exp_t;

  exp_t          sb[$];
  logic [FW-1:0] lr_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [FW-1:0] word, input logic ur);
    exp_t e;
    e.word = word;
    e.ur   = ur;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a frame_start pulse, sampling on falling clk edges.
  task automatic wait_fs(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    while (waited < 400) begin
      @(negedge clk);
      waited++;
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check("frame_start_timeout", frame_start, 1);
  endtask

  // Captures one frame from its frame_start and compares it with the scoreboard.
  task automatic capture_frame(input string tag, output int waited);
    logic [FW-1:0] word;
    logic [FW-1:0] lr;
    logic          ur;
    logic          shape_bad;
    bit            ok;
    exp_t          e;
    wait_fs(waited, ok);
    ur        = underrun;
    shape_bad = 1'b0;
    for (int k = 0; k < FW; k++) begin
      word[FW-1-k] = sdata;
      lr[k]        = lrclk;
      if (bclk !== 1'b0) shape_bad = 1'b1;
      repeat (DIV) @(negedge clk);
      if (bclk !== 1'b1 || sdata !== word[FW-1-k]) shape_bad = 1'b1;
      if (k < FW - 1) repeat (DIV) @(negedge clk);
    end
    if (sb.size() == 0) begin
      check($sformatf("%s_scoreboard_empty", tag), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s_word", tag), word, e.word);
      check($sformatf("%s_underrun", tag), ur, e.ur);
    end
    check($sformatf("%s_lrclk", tag), lr, lr_exp);
    check($sformatf("%s_bclk_shape", tag), shape_bad, 0);
  endtask

  // Presents a pair and waits (bounded) for the handshake; optionally keeps valid high.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit hold,
                      output int tcyc, output logic fs_after, output logic rdy_after);
    int n;
    n            = 0;
    tcyc         = 0;
    fs_after     = 1'b0;
    rdy_after    = 1'b0;
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    while (sample_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sample_ready !== 1'b1) begin
      check("send_ready_timeout", sample_ready, 1);
      sample_valid = 1'b0;
      return;
    end
    @(posedge clk);
    tcyc = cyc;
    push_exp({l, r}, 1'b0);
    @(negedge clk);
    fs_after  = frame_start;
    rdy_after = sample_ready;
    if (!hold) sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int       w;
    bit       ok;
    int       c1, c2, c3, c4;
    logic     fs, rdy;
    int       ur_miss;
    int       exp_cnt;
    logic [W-1:0] a_l, a_r, b_l, b_r;

    a_l = 16'h8001; a_r = 16'h7FFE;
    b_l = 16'hC3A5; b_r = 16'h0F0F;
    for (int k = 0; k < FW; k++) lr_exp[k] = (k >= W - 1) && (k <= FW - 2);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {sample_ready, bclk, lrclk, sdata, frame_start, underrun, underrun_count}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", {sample_ready, bclk, lrclk, sdata, frame_start, underrun_count}, {1'b1, 12'h0});

    // Single pair: latency, bit order and word select.
    send(a_l, a_r, 1'b0, c1, fs, rdy);
    check("fs_not_on_transfer_edge", fs, 0);
    capture_frame("frame1", w);
    check("frame1_fs_latency", w, 1);

    // No new data for three frames: the pair repeats with underruns.
    for (int f = 2; f <= 4; f++) begin
      push_exp({a_l, a_r}, 1'b1);
      capture_frame($sformatf("frame%0d", f), w);
    end
    check("ucnt_after_3", underrun_count, 3);

    // Streaming with valid held high, including refill at a full-buffer boundary.
    push_exp({a_l, a_r}, 1'b1);
    fork
      begin
        for (int f = 5; f <= 10; f++) capture_frame($sformatf("frame%0d", f), w);
      end
      begin
        repeat (20) @(negedge clk);
        send(16'h0001, 16'h8000, 1'b1, c1, fs, rdy);
        send(16'hAAAA, 16'h5555, 1'b1, c2, fs, rdy);
        check("refill_on_boundary", fs, 1);
        check("buffer_stays_full", rdy, 0);
        send(16'hFFFF, 16'h0000, 1'b1, c3, fs, rdy);
        check("transfer_period_p3", c3 - c2, 128);
        send(16'h1234, 16'hFEDC, 1'b0, c4, fs, rdy);
        check("transfer_period_p4", c4 - c3, 128);
        push_exp({16'h1234, 16'hFEDC}, 1'b1);
      end
    join
    check("ucnt_after_stream", underrun_count, 5);
    check("scoreboard_drained", sb.size(), 0);

    // Reset asserted at slot 20 of a frame.
    wait_fs(w, ok);
    repeat (20 * 2 * DIV + DIV) @(negedge clk);
    check("slot20_active", {bclk, lrclk, sdata}, 3'b111);
    reset = 1'b0;
    #1;
    check("reset_mid_frame", {bclk, lrclk, sdata, sample_ready, frame_start, underrun, underrun_count}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_release", {sample_ready, bclk, lrclk, sdata, underrun_count}, {1'b1, 11'h0});
    send(b_l, b_r, 1'b0, c1, fs, rdy);
    check("restart_fs_not_on_transfer_edge", fs, 0);
    capture_frame("restart", w);
    check("restart_fs_latency", w, 1);

    // Saturation of the underrun counter.
    ur_miss = 0;
    exp_cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      wait_fs(w, ok);
      if (!ok) break;
      if (underrun !== 1'b1) ur_miss++;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      if (i == 255 || i == 256 || i == 300)
        check($sformatf("ucnt_after_%0d", i), underrun_count, exp_cnt);
    end
    check("underrun_pulse_misses", ur_miss, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
